// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared constants and state encoding for the PRBS-15 pattern source
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PATTERN = 2'd1,
        ST_PRBS    = 2'd2
    } state_t;

    localparam int PRBS_WIDTH    = 15;
    localparam int TAP_HI        = 14;
    localparam int TAP_LO        = 13;
    localparam int PATTERN_WIDTH = 32;

    localparam logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = 32'hCCDDEEFF;
    localparam logic [PRBS_WIDTH-1:0]    DEFAULT_SEED    = 15'h0001;

    // x^15 + x^14 + 1, Fibonacci form: feedback enters at bit 0, output taken from bit 14
    function automatic logic [PRBS_WIDTH-1:0] lfsr_next(input logic [PRBS_WIDTH-1:0] s);
        return {s[PRBS_WIDTH-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// rtl/prbs15_lfsr.sv - PRBS-15 shift register with seed reload and step enable
module prbs15_lfsr
    import prbs_pkg::*;
#(
    parameter logic [PRBS_WIDTH-1:0] SEED = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    output logic [PRBS_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/prbs15_pattern_gen.sv
// rtl/prbs15_pattern_gen.sv - framing pattern repeated n times, then free-running PRBS-15
module prbs15_pattern_gen
    import prbs_pkg::*;
#(
    parameter logic [PATTERN_WIDTH-1:0] PATTERN = DEFAULT_PATTERN,
    parameter logic [PRBS_WIDTH-1:0]    SEED    = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] n,
    output logic       data,
    output logic       valid,
    output logic       prbs_phase
);

    state_t                state, state_nx;
    logic [4:0]            bit_cnt, bit_cnt_nx;
    logic [2:0]            rep_cnt, rep_cnt_nx;
    logic [2:0]            n_lat, n_lat_nx;
    logic                  data_nx, valid_nx, phase_nx;
    logic                  lfsr_load, lfsr_step;
    logic [PRBS_WIDTH-1:0] lfsr_q;

    prbs15_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        rep_cnt_nx = rep_cnt;
        n_lat_nx   = n_lat;
        data_nx    = 1'b0;
        valid_nx   = 1'b0;
        phase_nx   = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (en) begin
                    valid_nx = 1'b1;
                    n_lat_nx = n;
                    if (n != 3'd0) begin
                        state_nx   = ST_PATTERN;
                        data_nx    = PATTERN[PATTERN_WIDTH-1];
                        bit_cnt_nx = 5'd1;
                        rep_cnt_nx = 3'd0;
                    end else begin
                        state_nx  = ST_PRBS;
                        data_nx   = lfsr_q[TAP_HI];
                        phase_nx  = 1'b1;
                        lfsr_step = 1'b1;
                    end
                end
            end
            ST_PATTERN: begin
                valid_nx = 1'b1;
                // bit_cnt==0 here means a whole repetition has just gone out
                if (bit_cnt == 5'd0 && rep_cnt == n_lat) begin
                    state_nx   = ST_PRBS;
                    data_nx    = lfsr_q[TAP_HI];
                    phase_nx   = 1'b1;
                    lfsr_step  = 1'b1;
                    rep_cnt_nx = 3'd0;
                end else begin
                    data_nx    = PATTERN[5'd31 - bit_cnt];
                    bit_cnt_nx = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        rep_cnt_nx = rep_cnt + 3'd1;
                    end
                end
            end
            ST_PRBS: begin
                valid_nx  = 1'b1;
                data_nx   = lfsr_q[TAP_HI];
                phase_nx  = 1'b1;
                lfsr_step = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Dropping en aborts the run and rearms the LFSR so the next run is identical
        if (state != ST_IDLE && !en) begin
            state_nx   = ST_IDLE;
            bit_cnt_nx = 5'd0;
            rep_cnt_nx = 3'd0;
            data_nx    = 1'b0;
            valid_nx   = 1'b0;
            phase_nx   = 1'b0;
            lfsr_step  = 1'b0;
            lfsr_load  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 5'd0;
            rep_cnt    <= 3'd0;
            n_lat      <= 3'd0;
            data       <= 1'b0;
            valid      <= 1'b0;
            prbs_phase <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            rep_cnt    <= rep_cnt_nx;
            n_lat      <= n_lat_nx;
            data       <= data_nx;
            valid      <= valid_nx;
            prbs_phase <= phase_nx;
        end
    end

endmodule

// File: tb/tb_prbs15_pattern_gen.sv
// tb/tb_prbs15_pattern_gen.sv - scoreboard bench for prbs15_pattern_gen
module tb_prbs15_pattern_gen;

    localparam logic [31:0] PAT      = 32'hCCDDEEFF;
    localparam logic [14:0] SEED     = 15'h0001;
    localparam int          REF_LEN  = 32767 + 300;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [2:0] n   = 3'd0;
    logic       data, valid, prbs_phase;

    prbs15_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .n          (n),
        .data       (data),
        .valid      (valid),
        .prbs_phase (prbs_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit v;
        bit d;
        bit ph;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   prbs_ref [REF_LEN];

    bit   run_active = 0;
    int   run_pos = 0;
    int   run_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output sequence o[] of the polynomial obeys o[t+15] = o[t] ^ o[t+1]
    initial begin
        logic [14:0] s;
        s = SEED;
        for (int i = 0; i < 15; i++) prbs_ref[i] = s[14-i];
        for (int i = 15; i < REF_LEN; i++) prbs_ref[i] = prbs_ref[i-15] ^ prbs_ref[i-14];
    end

    function automatic bit ref_bit(input int p);
        if (p < REF_LEN) return prbs_ref[p];
        return prbs_ref[p % 32767];
    endfunction

    task automatic step(input bit r, input bit e, input logic [2:0] nv);
        exp_t it;
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        n   = nv;
        it.due = cyc + 1;
        it.v = 0; it.d = 0; it.ph = 0;
        if (!r || !e) begin
            run_active = 0;
            run_pos    = 0;
        end else begin
            if (!run_active) begin
                run_active = 1;
                run_n      = int'(nv);
                run_pos    = 0;
            end
            it.v = 1;
            if (run_pos < 32 * run_n) begin
                it.d  = PAT[31 - (run_pos % 32)];
                it.ph = 0;
            end else begin
                it.d  = ref_bit(run_pos - 32 * run_n);
                it.ph = 1;
            end
            run_pos++;
        end
        exp_q.push_back(it);
    endtask

    task automatic run(input logic [2:0] nv, input int len);
        for (int i = 0; i < len; i++) step(1'b1, 1'b1, nv);
    endtask

    task automatic idle(input int len);
        for (int i = 0; i < len; i++) step(1'b1, 1'b0, 3'($urandom_range(0, 7)));
    endtask

    initial begin : monitor
        exp_t it;
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                it = exp_q.pop_front();
                checks++;
                if (valid !== it.v) begin
                    failures++;
                    $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid, it.v);
                end
                checks++;
                if (data !== it.d) begin
                    failures++;
                    $display("FAIL data cyc=%0d got=%b exp=%b", cyc, data, it.d);
                end
                if (it.v) begin
                    checks++;
                    if (prbs_phase !== it.ph) begin
                        failures++;
                        $display("FAIL prbs_phase cyc=%0d got=%b exp=%b", cyc, prbs_phase, it.ph);
                    end
                end else if (!rst) begin
                    checks++;
                    if (prbs_phase !== 1'b0) begin
                        failures++;
                        $display("FAIL reset_phase cyc=%0d got=%b exp=0", cyc, prbs_phase);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int len;
        int gap;
        logic [2:0] nv;

        // Reset held with en high: nothing may start
        step(1'b0, 1'b1, 3'd1);
        step(1'b0, 1'b1, 3'd1);
        step(1'b0, 1'b1, 3'd1);

        // n=1: one framing word then seed-derived PRBS
        run(3'd1, 32 + 20);
        idle(2);

        // n=3 with n changed mid-run: latched value must hold
        run(3'd3, 10);
        run(3'd5, 96 + 30);
        idle(2);

        // n=0: PRBS across a full period and beyond
        run(3'd0, 32767 + 60);
        idle(2);

        // Abort at pattern bit 17, restart after 3 idle cycles
        run(3'd2, 18);
        idle(3);
        run(3'd2, 64 + 10);
        idle(1);

        // Reset pulse mid-PRBS with en held high
        run(3'd4, 128 + 20);
        step(1'b0, 1'b1, 3'd4);
        run(3'd4, 128 + 40);
        idle(2);

        // Randomised runs, n jitter during runs, aborts and reset pulses
        for (int k = 0; k < 40; k++) begin
            nv  = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 300);
            step(1'b1, 1'b1, nv);
            for (int i = 1; i < len; i++) step(1'b1, 1'b1, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end else begin
                gap = $urandom_range(1, 3);
                idle(gap);
            end
        end

        idle(2);
        repeat (4) @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs15_pattern_gen.md
# prbs15_pattern_gen

Serial stimulus source that sits directly upstream of `pattern_detect` and drives its `data` input. On start it emits a fixed 32-bit framing pattern MSB-first `n` times, then switches to a free-running PRBS-15 stream (x^15 + x^14 + 1) until disabled. The detector downstream receives the pattern repetitions followed by pseudo-random payload on one serial line, one bit per clock.

## Interface
- `PATTERN`, 32'hCCDDEEFF, framing word, serialized MSB-first.
- `SEED`, 15'h0001, LFSR load value; must be non-zero.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  run request; level-sensitive.
- `n`  in  3  number of pattern repetitions (0..7); sampled only at start.
- `data`  out  1  serial output bit, registered.
- `valid`  out  1  high while `data` carries a generated bit.
- `prbs_phase`  out  1  0 = pattern bits, 1 = PRBS bits; meaningful only when `valid`=1.

## Operation
- States: IDLE, PATTERN, PRBS.
- Reset (`rst`=0 at a rising edge): state IDLE, `data`=0, `valid`=0, `prbs_phase`=0, bit counter 0, repeat counter 0, LFSR=SEED. Reset overrides every other input.
- IDLE, `en`=0: stay, outputs held at reset values.
- IDLE, `en`=1, `n`≠0: latch `n`; `data`<=PATTERN[31], `valid`<=1, `prbs_phase`<=0; go to PATTERN with bit counter 1 and repeat counter 0.
- IDLE, `en`=1, `n`=0: go straight to PRBS; `data`<=LFSR[14], `valid`<=1, `prbs_phase`<=1; LFSR advances.
- PATTERN: each cycle `data`<=PATTERN[31-bit_cnt]. The 5-bit bit counter wraps from 31 to 0 and increments the repeat counter. After bit 0 of repetition `n`-1, the next cycle enters PRBS; no gap bit.
- PRBS: each cycle `data`<=LFSR[14], then LFSR<={LFSR[13:0], LFSR[14]^LFSR[13]}. The LFSR holds its value outside PRBS. Its period is 32767 and it never reaches zero.
- `en`=0 in PATTERN or PRBS: the next edge returns to IDLE with `data`=0 and `valid`=0. Counters clear. The LFSR reloads SEED, so every run is deterministic.
- Changes to `n` after start are ignored until the next start from IDLE.
- Total pattern bits per run = 32·n (max 224).

## Timing
- Latency: the first generated bit appears on `data` one edge after `en` is first sampled high in IDLE.
- One bit per cycle, no bubbles between pattern repetitions or at the PATTERN→PRBS boundary.
- `prbs_phase` changes on the same edge as the first PRBS bit.
- `en` deassertion: `valid` falls on the next edge. A bit already on `data` in that cycle was valid.
- Reset mid-run: same behaviour as `en` deassertion plus a forced IDLE, regardless of `en`.

## Structure
- Shared package `prbs_pkg`: state encoding, PRBS width (15), tap positions (14, 13), default PATTERN and SEED constants, pattern width (32). `pattern_detect` reuses the pattern constant from this package.
- Sub-module `prbs15_lfsr` (ports: clk, rst, load, step, q[14:0]) isolates the shift register. The FSM and the two counters live in the top module.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `en`=1 → `data`=0, `valid`=0, `prbs_phase`=0 throughout; no start until `rst`=1.
- `n`=1, `en`=1: first 32 valid bits = CC DD EE FF MSB-first (1,1,0,0,1,1,0,0,…). The next 15 bits with SEED=15'h0001 are fourteen 0s then 1, and `prbs_phase` rises on the first of those bits.
- `n`=3, with `n` driven to 5 after 10 cycles → exactly 96 pattern bits, then PRBS. Feeding `data` into `pattern_detect` (n=3) → `data_flag` asserts.
- `n`=0: PRBS from the first valid bit. After 32767 bits the LFSR equals SEED again, and it is never all-zero.
- Drop `en` at pattern bit 17, then reassert `en` 3 cycles later → `valid`=0 the next edge. The restart begins at PATTERN[31] with a fresh repeat count.
- Pulse `rst`=0 mid-PRBS with `en` held 1 → IDLE next edge. After release, the full pattern sequence replays and the PRBS restarts from SEED.
